// File: rtl/register_bank_sb.sv
// Parametrised register bank with a dedicated PC, four registered read ports,
// optional write-to-read bypass and a pending-write scoreboard for RAW hazards.
module register_bank_sb #(
  parameter int unsigned    BUS      = 32,
  parameter int unsigned    DIR      = 4,
  parameter int unsigned    PC_IDX   = 2**DIR - 1,
  parameter logic [BUS-1:0] PC_RESET = '0,
  parameter bit             ZERO_REG = 1'b0,
  parameter bit             BYPASS   = 1'b1
) (
  input  logic              clk,
  input  logic              rst,
  input  logic              re,
  input  logic [DIR-1:0]    rs,
  input  logic [DIR-1:0]    rx,
  input  logic [DIR-1:0]    rk,
  input  logic [DIR-1:0]    rd,
  output logic [BUS-1:0]    rs_d,
  output logic [BUS-1:0]    rx_d,
  output logic [BUS-1:0]    rk_d,
  output logic [BUS-1:0]    str_reg,
  input  logic              we,
  input  logic [DIR-1:0]    wa,
  input  logic [BUS-1:0]    wb,
  input  logic              pc_we,
  input  logic [BUS-1:0]    pc_i,
  output logic [BUS-1:0]    pc_o,
  input  logic              issue,
  input  logic [DIR-1:0]    issue_addr,
  output logic              hazard,
  output logic [2**DIR-1:0] pending
);

  localparam int unsigned    NReg   = 2**DIR;
  localparam logic [DIR-1:0] PcAddr = DIR'(PC_IDX);

  logic [BUS-1:0]  regs_q [NReg];
  logic [BUS-1:0]  regs_d [NReg];
  logic [BUS-1:0]  pc_q, pc_d;
  logic [BUS-1:0]  pc_o_q;
  logic [NReg-1:0] pend_q, pend_d;
  logic [BUS-1:0]  rdata_q [4];
  logic [BUS-1:0]  rdata_d [4];
  logic [DIR-1:0]  raddr [4];
  logic            any_pend;

  assign raddr[0] = rs;
  assign raddr[1] = rx;
  assign raddr[2] = rk;
  assign raddr[3] = rd;

  // A pending register stops being a hazard when its producer is being
  // forwarded on this very edge.
  always_comb begin
    any_pend = 1'b0;
    for (int i = 0; i < 4; i++) begin
      any_pend = any_pend |
                 (pend_q[raddr[i]] & ~(BYPASS & we & (wa == raddr[i])));
    end
    hazard = re & any_pend;
  end

  always_comb begin
    for (int i = 0; i < 4; i++) begin
      rdata_d[i] = rdata_q[i];
      if (re && !hazard) begin
        if (raddr[i] == PcAddr) begin
          rdata_d[i] = pc_q;
        end else if (ZERO_REG && raddr[i] == '0) begin
          rdata_d[i] = '0;
        end else if (BYPASS && we && wa == raddr[i]) begin
          rdata_d[i] = wb;
        end else begin
          rdata_d[i] = regs_q[raddr[i]];
        end
      end
    end
  end

  always_comb begin
    regs_d = regs_q;
    if (we && wa != PcAddr && !(ZERO_REG && wa == '0)) begin
      regs_d[wa] = wb;
    end
  end

  // pc_we wins over a general write aimed at the PC slot.
  always_comb begin
    pc_d = pc_q;
    if (pc_we) begin
      pc_d = pc_i;
    end else if (we && wa == PcAddr) begin
      pc_d = wb;
    end
  end

  // Clear first so a same-edge issue to the written address re-arms the bit.
  always_comb begin
    pend_d = pend_q;
    if (we) begin
      pend_d[wa] = 1'b0;
    end
    if (issue && issue_addr != PcAddr && !(ZERO_REG && issue_addr == '0)) begin
      pend_d[issue_addr] = 1'b1;
    end
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      regs_q  <= '{default: '0};
      pc_q    <= PC_RESET;
      pc_o_q  <= PC_RESET;
      pend_q  <= '0;
      rdata_q <= '{default: '0};
    end else begin
      regs_q  <= regs_d;
      pc_q    <= pc_d;
      pc_o_q  <= pc_d;
      pend_q  <= pend_d;
      rdata_q <= rdata_d;
    end
  end

  assign rs_d    = rdata_q[0];
  assign rx_d    = rdata_q[1];
  assign rk_d    = rdata_q[2];
  assign str_reg = rdata_q[3];
  assign pc_o    = pc_o_q;
  assign pending = pend_q;

endmodule

// File: tb/tb_register_bank_sb.sv
// Bench for register_bank_sb: directed table plus randomized traffic on two
// configurations (zero-reg+bypass, and plain no-bypass) against a reference model.
module tb_register_bank_sb;

  logic        clk = 1'b0;
  logic        rst, re, we, pc_we, issue;
  logic [3:0]  rs, rx, rk, rd, wa, ia;
  logic [31:0] wb, pc_i;

  logic [31:0] a_rs, a_rx, a_rk, a_st, a_pc;
  logic [31:0] b_rs, b_rx, b_rk, b_st, b_pc;
  logic        a_haz, b_haz;
  logic [15:0] a_pend, b_pend;

  always #5 clk = ~clk;

  register_bank_sb #(
    .BUS(32), .DIR(4), .PC_IDX(15), .PC_RESET(32'h100), .ZERO_REG(1'b1), .BYPASS(1'b1)
  ) dut_a (
    .clk(clk), .rst(rst), .re(re), .rs(rs), .rx(rx), .rk(rk), .rd(rd),
    .rs_d(a_rs), .rx_d(a_rx), .rk_d(a_rk), .str_reg(a_st),
    .we(we), .wa(wa), .wb(wb), .pc_we(pc_we), .pc_i(pc_i), .pc_o(a_pc),
    .issue(issue), .issue_addr(ia), .hazard(a_haz), .pending(a_pend)
  );

  register_bank_sb #(
    .BUS(32), .DIR(4), .PC_IDX(15), .PC_RESET(32'h0), .ZERO_REG(1'b0), .BYPASS(1'b0)
  ) dut_b (
    .clk(clk), .rst(rst), .re(re), .rs(rs), .rx(rx), .rk(rk), .rd(rd),
    .rs_d(b_rs), .rx_d(b_rx), .rk_d(b_rk), .str_reg(b_st),
    .we(we), .wa(wa), .wb(wb), .pc_we(pc_we), .pc_i(pc_i), .pc_o(b_pc),
    .issue(issue), .issue_addr(ia), .hazard(b_haz), .pending(b_pend)
  );

  int n_cmp = 0;
  int n_bad = 0;

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_cmp++;
    if (act !== exp) begin
      n_bad++;
      $display("FAIL %s: got %h, expected %h (t=%0t)", name, act, exp, $time);
    end
  endtask

  // Reference model: index 0 = dut_a config, 1 = dut_b config.
  bit          m_zero [2];
  bit          m_byp  [2];
  logic [31:0] m_pcr  [2];
  logic [31:0] m_reg  [2][16];
  logic [31:0] m_pc   [2];
  logic [31:0] m_pco  [2];
  logic [31:0] m_out  [2][4];
  logic [15:0] m_pend [2];

  function automatic logic m_hazard(int c);
    logic [3:0] ad [4];
    logic h = 1'b0;
    ad[0] = rs; ad[1] = rx; ad[2] = rk; ad[3] = rd;
    for (int i = 0; i < 4; i++)
      if (m_pend[c][ad[i]] && !(m_byp[c] && we && wa == ad[i])) h = 1'b1;
    return re && h;
  endfunction

  task automatic m_edge(int c);
    logic [3:0] ad [4];
    ad[0] = rs; ad[1] = rx; ad[2] = rk; ad[3] = rd;
    if (rst) begin
      for (int i = 0; i < 16; i++) m_reg[c][i] = 32'h0;
      for (int i = 0; i < 4; i++) m_out[c][i] = 32'h0;
      m_pc[c] = m_pcr[c]; m_pco[c] = m_pcr[c]; m_pend[c] = 16'h0;
    end else begin
      if (re && !m_hazard(c)) begin
        for (int i = 0; i < 4; i++) begin
          if (ad[i] == 4'd15)                       m_out[c][i] = m_pc[c];
          else if (m_zero[c] && ad[i] == 4'd0)      m_out[c][i] = 32'h0;
          else if (m_byp[c] && we && wa == ad[i])   m_out[c][i] = wb;
          else                                      m_out[c][i] = m_reg[c][ad[i]];
        end
      end
      if (pc_we)                 m_pc[c] = pc_i;
      else if (we && wa == 4'd15) m_pc[c] = wb;
      if (we && wa != 4'd15 && !(m_zero[c] && wa == 4'd0)) m_reg[c][wa] = wb;
      m_pco[c] = m_pc[c];
      if (we) m_pend[c][wa] = 1'b0;
      if (issue && ia != 4'd15 && !(m_zero[c] && ia == 4'd0)) m_pend[c][ia] = 1'b1;
    end
  endtask

  task automatic chk_model(int c, string tag);
    if (c == 0) begin
      chk({tag, "_a_rs"}, a_rs, m_out[0][0]);  chk({tag, "_a_rx"}, a_rx, m_out[0][1]);
      chk({tag, "_a_rk"}, a_rk, m_out[0][2]);  chk({tag, "_a_st"}, a_st, m_out[0][3]);
      chk({tag, "_a_pc"}, a_pc, m_pco[0]);     chk({tag, "_a_pend"}, {16'h0, a_pend}, {16'h0, m_pend[0]});
    end else begin
      chk({tag, "_b_rs"}, b_rs, m_out[1][0]);  chk({tag, "_b_rx"}, b_rx, m_out[1][1]);
      chk({tag, "_b_rk"}, b_rk, m_out[1][2]);  chk({tag, "_b_st"}, b_st, m_out[1][3]);
      chk({tag, "_b_pc"}, b_pc, m_pco[1]);     chk({tag, "_b_pend"}, {16'h0, b_pend}, {16'h0, m_pend[1]});
    end
  endtask

  typedef struct {
    logic        rst, re;
    logic [3:0]  rs, rx;
    logic        we;
    logic [3:0]  wa;
    logic [31:0] wb;
    logic        pc_we;
    logic [31:0] pc_i;
    logic        issue;
    logic [3:0]  ia;
    logic        e_haz;
    logic [31:0] e_rs, e_rx, e_pc;
    logic [15:0] e_pend;
  } vec_t;

  vec_t tbl [$];

  function automatic vec_t mk(bit r, bit e, logic [3:0] s, logic [3:0] x, bit w,
                              logic [3:0] a, logic [31:0] d, bit pw, logic [31:0] pi,
                              bit is, logic [3:0] iad, bit h, logic [31:0] ers,
                              logic [31:0] erx, logic [31:0] epc, logic [15:0] ep);
    vec_t v;
    v.rst = r; v.re = e; v.rs = s; v.rx = x; v.we = w; v.wa = a; v.wb = d;
    v.pc_we = pw; v.pc_i = pi; v.issue = is; v.ia = iad;
    v.e_haz = h; v.e_rs = ers; v.e_rx = erx; v.e_pc = epc; v.e_pend = ep;
    return v;
  endfunction

  initial begin
    m_zero[0] = 1'b1; m_byp[0] = 1'b1; m_pcr[0] = 32'h100;
    m_zero[1] = 1'b0; m_byp[1] = 1'b0; m_pcr[1] = 32'h0;
    for (int c = 0; c < 2; c++) begin
      for (int i = 0; i < 16; i++) m_reg[c][i] = 32'h0;
      for (int i = 0; i < 4; i++) m_out[c][i] = 32'h0;
      m_pc[c] = 32'h0; m_pco[c] = 32'h0; m_pend[c] = 16'h0;
    end
    rst = 1'b1; re = 1'b0; rs = '0; rx = '0; rk = '0; rd = '0; we = 1'b0; wa = '0;
    wb = '0; pc_we = 1'b0; pc_i = '0; issue = 1'b0; ia = '0;

    // Expectations below are for dut_a (PC_RESET=0x100, ZERO_REG=1, BYPASS=1).
    //            rst re rs    rx    we wa    wb            pcwe pc_i      iss ia   haz e_rs          e_rx          e_pc      e_pend
    tbl.push_back(mk(1, 0, 4'd0, 4'd0, 0, 4'd0, 32'h0,        0, 32'h0,   0, 4'd0, 0, 32'h0,        32'h0,        32'h100, 16'h0));
    tbl.push_back(mk(1, 0, 4'd0, 4'd0, 0, 4'd0, 32'h0,        0, 32'h0,   0, 4'd0, 0, 32'h0,        32'h0,        32'h100, 16'h0));
    tbl.push_back(mk(0, 1, 4'd7, 4'd1, 0, 4'd0, 32'h0,        0, 32'h0,   0, 4'd0, 0, 32'h0,        32'h0,        32'h100, 16'h0));
    tbl.push_back(mk(0, 0, 4'd0, 4'd0, 1, 4'd3, 32'hDEADBEEF, 0, 32'h0,   0, 4'd0, 0, 32'h0,        32'h0,        32'h100, 16'h0));
    tbl.push_back(mk(0, 1, 4'd3, 4'd0, 0, 4'd0, 32'h0,        0, 32'h0,   0, 4'd0, 0, 32'hDEADBEEF, 32'h0,        32'h100, 16'h0));
    tbl.push_back(mk(0, 1, 4'd4, 4'd3, 1, 4'd4, 32'h1234,     0, 32'h0,   0, 4'd0, 0, 32'h1234,     32'hDEADBEEF, 32'h100, 16'h0));
    tbl.push_back(mk(0, 0, 4'd0, 4'd0, 1, 4'hF, 32'h999,      1, 32'h200, 0, 4'd0, 0, 32'h1234,     32'hDEADBEEF, 32'h200, 16'h0));
    tbl.push_back(mk(0, 0, 4'd0, 4'd0, 1, 4'hF, 32'h999,      0, 32'h0,   0, 4'd0, 0, 32'h1234,     32'hDEADBEEF, 32'h999, 16'h0));
    tbl.push_back(mk(0, 0, 4'd0, 4'd0, 0, 4'd0, 32'h0,        0, 32'h0,   0, 4'd0, 0, 32'h1234,     32'hDEADBEEF, 32'h999, 16'h0));
    tbl.push_back(mk(0, 1, 4'hF, 4'd3, 0, 4'd0, 32'h0,        0, 32'h0,   0, 4'd0, 0, 32'h999,      32'hDEADBEEF, 32'h999, 16'h0));
    tbl.push_back(mk(0, 0, 4'd0, 4'd0, 0, 4'd0, 32'h0,        0, 32'h0,   1, 4'd5, 0, 32'h999,      32'hDEADBEEF, 32'h999, 16'h0020));
    tbl.push_back(mk(0, 1, 4'd3, 4'd5, 0, 4'd0, 32'h0,        0, 32'h0,   0, 4'd0, 1, 32'h999,      32'hDEADBEEF, 32'h999, 16'h0020));
    tbl.push_back(mk(0, 1, 4'd3, 4'd5, 1, 4'd5, 32'h7,        0, 32'h0,   0, 4'd0, 0, 32'hDEADBEEF, 32'h7,        32'h999, 16'h0));
    tbl.push_back(mk(0, 0, 4'd0, 4'd0, 1, 4'd6, 32'h66,       0, 32'h0,   1, 4'd6, 0, 32'hDEADBEEF, 32'h7,        32'h999, 16'h0040));
    tbl.push_back(mk(0, 1, 4'd0, 4'd3, 1, 4'd0, 32'hFFFF,     0, 32'h0,   1, 4'd0, 0, 32'h0,        32'hDEADBEEF, 32'h999, 16'h0040));
    tbl.push_back(mk(0, 1, 4'd0, 4'd3, 0, 4'd0, 32'h0,        0, 32'h0,   0, 4'd0, 0, 32'h0,        32'hDEADBEEF, 32'h999, 16'h0040));
    tbl.push_back(mk(0, 0, 4'd0, 4'd0, 0, 4'd0, 32'h0,        1, 32'h40,  1, 4'd2, 0, 32'h0,        32'hDEADBEEF, 32'h40,  16'h0044));
    tbl.push_back(mk(1, 0, 4'd0, 4'd0, 1, 4'd2, 32'h22,       0, 32'h0,   1, 4'd9, 0, 32'h0,        32'h0,        32'h100, 16'h0));
    tbl.push_back(mk(0, 1, 4'd2, 4'd3, 0, 4'd0, 32'h0,        0, 32'h0,   0, 4'd0, 0, 32'h0,        32'h0,        32'h100, 16'h0));

    foreach (tbl[k]) begin
      @(negedge clk);
      rst = tbl[k].rst; re = tbl[k].re; rs = tbl[k].rs; rx = tbl[k].rx; rk = '0; rd = '0;
      we = tbl[k].we; wa = tbl[k].wa; wb = tbl[k].wb; pc_we = tbl[k].pc_we;
      pc_i = tbl[k].pc_i; issue = tbl[k].issue; ia = tbl[k].ia;
      #1;
      chk($sformatf("tbl%0d_a_haz", k), {31'h0, a_haz}, {31'h0, tbl[k].e_haz});
      chk($sformatf("tbl%0d_b_haz", k), {31'h0, b_haz}, {31'h0, m_hazard(1)});
      @(posedge clk);
      m_edge(0);
      m_edge(1);
      #1;
      chk($sformatf("tbl%0d_a_rs", k), a_rs, tbl[k].e_rs);
      chk($sformatf("tbl%0d_a_rx", k), a_rx, tbl[k].e_rx);
      chk($sformatf("tbl%0d_a_pc", k), a_pc, tbl[k].e_pc);
      chk($sformatf("tbl%0d_a_pend", k), {16'h0, a_pend}, {16'h0, tbl[k].e_pend});
      chk_model(1, $sformatf("tbl%0d", k));
    end

    // Randomized traffic, addresses biased low so hazards and bypasses are frequent.
    for (int n = 0; n < 800; n++) begin
      @(negedge clk);
      rst   = ($urandom_range(0, 39) == 0);
      re    = ($urandom_range(0, 3) != 0);
      rs    = ($urandom_range(0, 7) == 0) ? 4'hF : 4'($urandom_range(0, 7));
      rx    = ($urandom_range(0, 7) == 0) ? 4'hF : 4'($urandom_range(0, 7));
      rk    = 4'($urandom_range(0, 7));
      rd    = 4'($urandom_range(0, 15));
      we    = ($urandom_range(0, 1) == 1);
      wa    = ($urandom_range(0, 7) == 0) ? 4'hF : 4'($urandom_range(0, 7));
      wb    = $urandom;
      pc_we = ($urandom_range(0, 2) == 0);
      pc_i  = $urandom;
      issue = ($urandom_range(0, 2) == 0);
      ia    = ($urandom_range(0, 7) == 0) ? 4'hF : 4'($urandom_range(0, 7));
      #1;
      chk($sformatf("rnd%0d_a_haz", n), {31'h0, a_haz}, {31'h0, m_hazard(0)});
      chk($sformatf("rnd%0d_b_haz", n), {31'h0, b_haz}, {31'h0, m_hazard(1)});
      @(posedge clk);
      m_edge(0);
      m_edge(1);
      #1;
      chk_model(0, $sformatf("rnd%0d", n));
      chk_model(1, $sformatf("rnd%0d", n));
    end

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
    $finish;
  end

endmodule
